// File: rtl/rv_pkg.sv
// Shared integer-register-file constants and types for the decode stage.
// No logic; pure declarations.
// No flow control; consumed at elaboration time only.
package rv_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_idx_t;

endpackage

// File: rtl/rf_read_port.sv
// One register-file read port: range/zero masking, write bypass, pending flag.
// Latency: 0 cycles, purely combinational.
// No backpressure; a read is always served in the cycle it is presented.
module rf_read_port
    import rv_pkg::*;
#(
    parameter int XLEN    = rv_pkg::XLEN,
    parameter int NREGS   = rv_pkg::NREGS,
    parameter int AW      = rv_pkg::REG_AW,
    parameter int NWR     = 2,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1
) (
    input  logic [AW-1:0]         rd_addr_i,
    input  logic [NREGS*XLEN-1:0] mem_i,
    input  logic [NREGS-1:0]      pend_i,
    input  logic [NWR-1:0]        wr_en_i,
    input  logic [NWR*AW-1:0]     wr_addr_i,
    input  logic [NWR*XLEN-1:0]   wr_data_i,
    output logic [XLEN-1:0]       rd_data_o,
    output logic                  rd_pend_o
);

    // An address names real storage only if it is in range and is not the hardwired zero reg.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < NREGS) && !(ZERO_R0 && (a == '0));
    endfunction

    // Stored value first, then let the highest-index matching writer override it.
    always_comb begin
        rd_data_o = '0;
        rd_pend_o = 1'b0;
        if (addr_ok(rd_addr_i)) begin
            for (int i = 0; i < NREGS; i++) begin
                if (rd_addr_i == AW'(i)) begin
                    rd_data_o = mem_i[i*XLEN +: XLEN];
                    rd_pend_o = pend_i[i];
                end
            end
            if (BYPASS) begin
                for (int j = 0; j < NWR; j++) begin
                    if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == rd_addr_i)) begin
                        rd_data_o = wr_data_i[j*XLEN +: XLEN];
                        rd_pend_o = 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write bypass and a per-register pending scoreboard.
// Latency: reads 0 cycles; writes, pend bits, pend_cnt and dup_alloc update on the next edge.
// No backpressure: writes and allocs are always accepted; hazards are only reported.
module regfile_mp_sb
    import rv_pkg::*;
#(
    parameter int XLEN    = rv_pkg::XLEN,
    parameter int NREGS   = rv_pkg::NREGS,
    parameter int AW      = rv_pkg::REG_AW,
    parameter int NRD     = 2,
    parameter int NWR     = 2,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_pend,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    output logic [AW:0]         pend_cnt,
    output logic                dup_alloc
);

    logic [XLEN-1:0]       mem_q [NREGS];
    logic [NREGS*XLEN-1:0] mem_flat;
    logic [NREGS-1:0]      pend_q;
    logic [NREGS-1:0]      pend_d;
    logic [NREGS-1:0]      wr_hit;
    logic [XLEN-1:0]       wr_val [NREGS];
    logic [NREGS-1:0]      alloc_hit;
    logic [AW:0]           pend_cnt_q;
    logic [AW:0]           pend_cnt_d;
    logic                  dup_q;
    logic                  dup_d;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < NREGS) && !(ZERO_R0 && (a == '0));
    endfunction

    // Per-register write decode; later (higher-index) ports overwrite earlier ones.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            wr_hit[i] = 1'b0;
            wr_val[i] = '0;
        end
        for (int j = 0; j < NWR; j++) begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_en[j] && addr_ok(wr_addr[j*AW +: AW]) && (wr_addr[j*AW +: AW] == AW'(i))) begin
                    wr_hit[i] = 1'b1;
                    wr_val[i] = wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    // Scoreboard next state: a new producer (alloc) wins over a retiring one (write).
    always_comb begin
        pend_cnt_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            alloc_hit[i] = alloc_en && addr_ok(alloc_addr) && (alloc_addr == AW'(i));
            if (alloc_hit[i]) begin
                pend_d[i] = 1'b1;
            end else if (wr_hit[i]) begin
                pend_d[i] = 1'b0;
            end else begin
                pend_d[i] = pend_q[i];
            end
            pend_cnt_d = pend_cnt_d + {{AW{1'b0}}, pend_d[i]};
        end
        dup_d = |(alloc_hit & pend_q & ~wr_hit);
    end

    // Storage, scoreboard and status registers; rst wins over any same-cycle write or alloc.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
            pend_q     <= '0;
            pend_cnt_q <= '0;
            dup_q      <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_hit[i]) begin
                    mem_q[i] <= wr_val[i];
                end
            end
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
            dup_q      <= dup_d;
        end
    end

    // Flatten storage so each read port sees the whole array on one vector.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            mem_flat[i*XLEN +: XLEN] = mem_q[i];
        end
    end

    assign pend_cnt  = pend_cnt_q;
    assign dup_alloc = dup_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        rf_read_port #(
            .XLEN    (XLEN),
            .NREGS   (NREGS),
            .AW      (AW),
            .NWR     (NWR),
            .ZERO_R0 (ZERO_R0),
            .BYPASS  (BYPASS)
        ) u_rd (
            .rd_addr_i (rd_addr[k*AW +: AW]),
            .mem_i     (mem_flat),
            .pend_i    (pend_q),
            .wr_en_i   (wr_en),
            .wr_addr_i (wr_addr),
            .wr_data_i (wr_data),
            .rd_data_o (rd_data[k*XLEN +: XLEN]),
            .rd_pend_o (rd_pend[k])
        );
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: directed vector table plus randomized traffic vs. a reference model.
// Inputs change on the falling edge; combinational reads are sampled 1 time unit later.
// Registered outputs are sampled on the falling edge after the rising edge that updates them.
module tb_regfile_mp_sb;

    logic        clk;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_pend;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        alloc_en;
    logic [4:0]  alloc_addr;
    logic [5:0]  pend_cnt;
    logic        dup_alloc;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural state described directly by the rules.
    logic [31:0] m_mem [32];
    bit          m_pend [32];
    int          m_cnt;
    bit          m_dup;

    regfile_mp_sb dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_pend    (rd_pend),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .pend_cnt   (pend_cnt),
        .dup_alloc  (dup_alloc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        ae;
        logic [4:0]  aa;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic        e_p0;
        logic        e_p1;
        logic [5:0]  e_cnt;
        logic        e_dup;
    } vec_t;

    vec_t vt [17];

    function automatic vec_t mk(input logic r, input logic [1:0] we,
                                input logic [4:0] wa0, input logic [31:0] wd0,
                                input logic [4:0] wa1, input logic [31:0] wd1,
                                input logic ae, input logic [4:0] aa,
                                input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic p0, input logic p1,
                                input logic [5:0] cnt, input logic dup);
        vec_t v;
        v.rst = r; v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.ae = ae; v.aa = aa; v.ra0 = ra0; v.ra1 = ra1;
        v.e_rd0 = e0; v.e_rd1 = e1; v.e_p0 = p0; v.e_p1 = p1; v.e_cnt = cnt; v.e_dup = dup;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit ok(input logic [4:0] a);
        return a != 5'd0;
    endfunction

    // What a read of address a should return given current stored state and current writes.
    function automatic void model_read(input logic [4:0] a, output logic [31:0] d, output logic p);
        d = 32'h0;
        p = 1'b0;
        if (ok(a)) begin
            d = m_mem[a];
            p = m_pend[a];
            for (int j = 0; j < 2; j++) begin
                if (wr_en[j] && wr_addr[j*5 +: 5] == a) begin
                    d = wr_data[j*32 +: 32];
                    p = 1'b0;
                end
            end
        end
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        bit wrote [32];
        logic [4:0] a;
        for (int i = 0; i < 32; i++) wrote[i] = 1'b0;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i]  = 32'h0;
                m_pend[i] = 1'b0;
            end
            m_dup = 1'b0;
        end else begin
            for (int j = 0; j < 2; j++) begin
                a = wr_addr[j*5 +: 5];
                if (wr_en[j] && ok(a)) begin
                    m_mem[a] = wr_data[j*32 +: 32];
                    wrote[a] = 1'b1;
                end
            end
            m_dup = alloc_en && ok(alloc_addr) && m_pend[alloc_addr] && !wrote[alloc_addr];
            for (int i = 0; i < 32; i++) if (wrote[i]) m_pend[i] = 1'b0;
            if (alloc_en && ok(alloc_addr)) m_pend[alloc_addr] = 1'b1;
        end
        m_cnt = 0;
        for (int i = 0; i < 32; i++) m_cnt += int'(m_pend[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; wr_en = 2'b00; wr_addr = '0; wr_data = '0;
        alloc_en = 1'b0; alloc_addr = '0; rd_addr = '0;
    endtask

    task automatic check_reads_vs_model(input string tag);
        logic [31:0] d;
        logic p;
        for (int k = 0; k < 2; k++) begin
            model_read(rd_addr[k*5 +: 5], d, p);
            chk({tag, "_rd_data"}, {32'h0, rd_data[k*32 +: 32]}, {32'h0, d});
            chk({tag, "_rd_pend"}, {63'h0, rd_pend[k]}, {63'h0, p});
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = 32'h0;
            m_pend[i] = 1'b0;
        end
        m_cnt = 0;
        m_dup = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_pend_cnt", {58'h0, pend_cnt}, 64'h0);
        chk("reset_dup", {63'h0, dup_alloc}, 64'h0);

        // Random writes and allocs, then reset held two cycles: everything must clear.
        for (int c = 0; c < 8; c++) begin
            wr_en = 2'($urandom);
            wr_addr = 10'($urandom);
            wr_data = {$urandom, $urandom};
            alloc_en = 1'b1;
            alloc_addr = 5'($urandom_range(1, 31));
            tick();
        end
        rst = 1'b1;
        tick();
        tick();
        idle_inputs();
        chk("rst_pend_cnt", {58'h0, pend_cnt}, 64'h0);
        for (int i = 0; i < 16; i++) begin
            rd_addr = {5'(i + 16), 5'(i)};
            #1;
            chk("rst_rd0", {32'h0, rd_data[31:0]}, 64'h0);
            chk("rst_rd1", {32'h0, rd_data[63:32]}, 64'h0);
            chk("rst_pend", {62'h0, rd_pend}, 64'h0);
            tick();
        end

        // Directed vectors: bypass, write priority, r0, scoreboard, dup pulse, reset override.
        vt[0]  = mk(0, 2'b01, 5, 32'hDEADBEEF, 0, 0,        0, 0,  5, 5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0);
        vt[1]  = mk(0, 2'b00, 0, 0,            0, 0,        0, 0,  5, 0,  32'hDEADBEEF, 0,            0, 0, 0, 0);
        vt[2]  = mk(0, 2'b11, 7, 32'h11,       7, 32'h22,   0, 0,  7, 5,  32'h22,       32'hDEADBEEF, 0, 0, 0, 0);
        vt[3]  = mk(0, 2'b00, 0, 0,            0, 0,        0, 0,  7, 7,  32'h22,       32'h22,       0, 0, 0, 0);
        vt[4]  = mk(0, 2'b01, 0, 32'h1234,     0, 0,        1, 0,  0, 7,  0,            32'h22,       0, 0, 0, 0);
        vt[5]  = mk(0, 2'b00, 0, 0,            0, 0,        1, 3,  3, 0,  0,            0,            0, 0, 1, 0);
        vt[6]  = mk(0, 2'b00, 0, 0,            0, 0,        1, 3,  3, 7,  0,            32'h22,       1, 0, 1, 1);
        vt[7]  = mk(0, 2'b00, 0, 0,            0, 0,        0, 0,  3, 3,  0,            0,            1, 1, 1, 0);
        vt[8]  = mk(0, 2'b10, 0, 0,            3, 32'hCAFE, 0, 0,  3, 7,  32'hCAFE,     32'h22,       0, 0, 0, 0);
        vt[9]  = mk(0, 2'b00, 0, 0,            0, 0,        0, 0,  3, 5,  32'hCAFE,     32'hDEADBEEF, 0, 0, 0, 0);
        vt[10] = mk(0, 2'b01, 9, 32'h99,       0, 0,        1, 9,  9, 3,  32'h99,       32'hCAFE,     0, 0, 1, 0);
        vt[11] = mk(0, 2'b00, 0, 0,            0, 0,        1, 4,  9, 4,  32'h99,       0,            1, 0, 2, 0);
        vt[12] = mk(1, 2'b01, 12, 32'h55,      0, 0,        1, 10, 9, 4,  32'h99,       0,            1, 1, 0, 0);
        vt[13] = mk(0, 2'b00, 0, 0,            0, 0,        0, 0,  9, 12, 0,            0,            0, 0, 0, 0);
        vt[14] = mk(0, 2'b00, 0, 0,            0, 0,        1, 6,  6, 4,  0,            0,            0, 0, 1, 0);
        vt[15] = mk(0, 2'b01, 6, 32'h66,       0, 0,        1, 6,  6, 6,  32'h66,       32'h66,       0, 0, 1, 0);
        vt[16] = mk(0, 2'b00, 0, 0,            0, 0,        0, 0,  6, 9,  32'h66,       0,            1, 0, 1, 0);

        for (int r = 0; r < 17; r++) begin
            rst        = vt[r].rst;
            wr_en      = vt[r].we;
            wr_addr    = {vt[r].wa1, vt[r].wa0};
            wr_data    = {vt[r].wd1, vt[r].wd0};
            alloc_en   = vt[r].ae;
            alloc_addr = vt[r].aa;
            rd_addr    = {vt[r].ra1, vt[r].ra0};
            #1;
            chk($sformatf("vec%0d_rd0", r), {32'h0, rd_data[31:0]}, {32'h0, vt[r].e_rd0});
            chk($sformatf("vec%0d_rd1", r), {32'h0, rd_data[63:32]}, {32'h0, vt[r].e_rd1});
            chk($sformatf("vec%0d_pend", r), {62'h0, rd_pend}, {62'h0, vt[r].e_p1, vt[r].e_p0});
            tick();
            chk($sformatf("vec%0d_pend_cnt", r), {58'h0, pend_cnt}, {58'h0, vt[r].e_cnt});
            chk($sformatf("vec%0d_dup", r), {63'h0, dup_alloc}, {63'h0, vt[r].e_dup});
        end
        idle_inputs();

        // Randomized traffic against the model; addresses biased low to provoke collisions.
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 99) == 0);
            wr_en      = 2'($urandom);
            wr_addr    = {5'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 7 : 31)),
                          5'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 7 : 31))};
            wr_data    = {$urandom, $urandom};
            alloc_en   = ($urandom_range(0, 2) != 0);
            alloc_addr = 5'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 7 : 31));
            rd_addr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
            #1;
            check_reads_vs_model("rnd");
            tick();
            chk("rnd_pend_cnt", {58'h0, pend_cnt}, 64'(m_cnt));
            chk("rnd_dup", {63'h0, dup_alloc}, {63'h0, m_dup});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
